// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands in a small FIFO, issues them
// one at a time to the ALU and returns results (or timeouts) in order.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   cmd_valid_i/ready_o     command handshake, carries cmd_a/b/opcode_i
//   alu_a/b/opcode_o        operands to ALU, held stable while in flight
//   alu_start_o             one-cycle issue pulse
//   alu_result_i/done_i     registered ALU result and completion strobe
//   rsp_valid_o/ready_i     response handshake
//   rsp_result/opcode/error response payload (result 0 on timeout)
//   busy_o                  command in flight or queued

module alu_cmd_sequencer #(
  parameter int INPUT_DATA_BITS = 8,
  parameter int OPCODE_BITS     = 3,
  parameter int FIFO_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [INPUT_DATA_BITS-1:0]   cmd_a_i,
  input  logic [INPUT_DATA_BITS-1:0]   cmd_b_i,
  input  logic [OPCODE_BITS-1:0]       cmd_opcode_i,
  output logic [INPUT_DATA_BITS-1:0]   alu_a_o,
  output logic [INPUT_DATA_BITS-1:0]   alu_b_o,
  output logic [OPCODE_BITS-1:0]       alu_opcode_o,
  output logic                         alu_start_o,
  input  logic [2*INPUT_DATA_BITS-1:0] alu_result_i,
  input  logic                         alu_done_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [2*INPUT_DATA_BITS-1:0] rsp_result_o,
  output logic [OPCODE_BITS-1:0]       rsp_opcode_o,
  output logic                         rsp_error_o,
  output logic                         busy_o
);

  localparam int IDB   = INPUT_DATA_BITS;
  localparam int OPB   = OPCODE_BITS;
  localparam int RW    = 2 * INPUT_DATA_BITS;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  typedef struct packed {
    logic [IDB-1:0] a;
    logic [IDB-1:0] b;
    logic [OPB-1:0] op;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // ------------------------------------------------------------
  // Command FIFO
  // ------------------------------------------------------------
  cmd_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  cmd_t             push_cmd;
  cmd_t             head_cmd;

  state_t state_q;
  state_t state_d;

  assign fifo_empty  = (count_q == '0);
  assign cmd_ready_o = (count_q != FULL_CNT);
  assign push        = cmd_valid_i && cmd_ready_o;
  // Only IDLE drains the FIFO, so at most one command is ever in flight.
  assign pop         = (state_q == IDLE) && !fifo_empty;

  assign push_cmd.a  = cmd_a_i;
  assign push_cmd.b  = cmd_b_i;
  assign push_cmd.op = cmd_opcode_i;
  assign head_cmd    = fifo_mem[rd_ptr_q];

  // Storage needs no reset; occupancy is tracked by the count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= push_cmd;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ------------------------------------------------------------
  // Issue / wait / respond FSM
  // ------------------------------------------------------------
  logic [IDB-1:0]   alu_a_q;
  logic [IDB-1:0]   alu_a_d;
  logic [IDB-1:0]   alu_b_q;
  logic [IDB-1:0]   alu_b_d;
  logic [OPB-1:0]   alu_op_q;
  logic [OPB-1:0]   alu_op_d;
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] tmo_d;
  logic [RW-1:0]    rsp_res_q;
  logic [RW-1:0]    rsp_res_d;
  logic [OPB-1:0]   rsp_op_q;
  logic [OPB-1:0]   rsp_op_d;
  logic             rsp_err_q;
  logic             rsp_err_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      tmo_q     <= '0;
      rsp_res_q <= '0;
      rsp_op_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      tmo_q     <= tmo_d;
      rsp_res_q <= rsp_res_d;
      rsp_op_q  <= rsp_op_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    tmo_d     = tmo_q;
    rsp_res_d = rsp_res_q;
    rsp_op_d  = rsp_op_q;
    rsp_err_d = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          alu_a_d  = head_cmd.a;
          alu_b_d  = head_cmd.b;
          alu_op_d = head_cmd.op;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = TMO_W'(1);
        state_d = WAIT;
      end
      WAIT: begin
        // Done is checked first so a late done still beats the timeout.
        if (alu_done_i) begin
          rsp_res_d = alu_result_i;
          rsp_op_d  = alu_op_q;
          rsp_err_d = 1'b0;
          state_d   = RESP;
        end else if (tmo_q == TMO_MAX) begin
          rsp_res_d = '0;
          rsp_op_d  = alu_op_q;
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_opcode_o = alu_op_q;
  assign alu_start_o  = (state_q == ISSUE);
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_result_o = rsp_res_q;
  assign rsp_opcode_o = rsp_op_q;
  assign rsp_error_o  = rsp_err_q;
  assign busy_o       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed bench for alu_cmd_sequencer with a
// small registered ALU model in the loop.

module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [7:0]  cmd_a_i = '0;
  logic [7:0]  cmd_b_i = '0;
  logic [2:0]  cmd_opcode_i = '0;
  logic [7:0]  alu_a_o;
  logic [7:0]  alu_b_o;
  logic [2:0]  alu_opcode_o;
  logic        alu_start_o;
  logic [15:0] alu_result_i;
  logic        alu_done_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [15:0] rsp_result_o;
  logic [2:0]  rsp_opcode_o;
  logic        rsp_error_o;
  logic        busy_o;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .INPUT_DATA_BITS(8),
    .OPCODE_BITS(3),
    .FIFO_DEPTH(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_a_i(cmd_a_i),
    .cmd_b_i(cmd_b_i),
    .cmd_opcode_i(cmd_opcode_i),
    .alu_a_o(alu_a_o),
    .alu_b_o(alu_b_o),
    .alu_opcode_o(alu_opcode_o),
    .alu_start_o(alu_start_o),
    .alu_result_i(alu_result_i),
    .alu_done_i(alu_done_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o),
    .rsp_opcode_o(rsp_opcode_o),
    .rsp_error_o(rsp_error_o),
    .busy_o(busy_o)
  );

  // Tiny ALU: registered result, done one cycle after start, no done
  // for opcodes 5-7.
  logic        alu_done_q;
  logic [15:0] alu_res_q;
  logic        inj_done = 1'b0;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      alu_done_q <= 1'b0;
      alu_res_q  <= '0;
    end else begin
      alu_done_q <= alu_start_o && (alu_opcode_o <= 3'd4);
      if (alu_start_o) begin
        case (alu_opcode_o)
          3'd1:    alu_res_q <= {8'h00, alu_a_o} + {8'h00, alu_b_o};
          3'd2:    alu_res_q <= {8'h00, alu_a_o & alu_b_o};
          3'd3:    alu_res_q <= {8'h00, alu_a_o ^ alu_b_o};
          3'd4:    alu_res_q <= {8'h00, alu_a_o} * {8'h00, alu_b_o};
          default: alu_res_q <= 16'h0000;
        endcase
      end
    end
  end

  assign alu_result_i = alu_res_q;
  assign alu_done_i   = alu_done_q | inj_done;

  // Cycle counter and response monitor.
  int          cyc = 0;
  int          start_cnt = 0;
  int          last_start = -1;
  int          valid_rise = -1;
  logic        prev_valid = 1'b0;
  logic [15:0] q_res[$];
  logic [2:0]  q_op[$];
  logic        q_err[$];

  always @(posedge clk) begin
    if (alu_start_o) begin
      start_cnt++;
      last_start = cyc;
    end
    if (rsp_valid_o && !prev_valid) valid_rise = cyc;
    if (rsp_valid_o && rsp_ready_i) begin
      q_res.push_back(rsp_result_o);
      q_op.push_back(rsp_opcode_o);
      q_err.push_back(rsp_error_o);
    end
    prev_valid = rsp_valid_o;
    cyc++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, output int acc);
    int g;
    g = 0;
    cmd_a_i      = a;
    cmd_b_i      = b;
    cmd_opcode_i = op;
    cmd_valid_i  = 1'b1;
    while (!cmd_ready_o && g < 200) begin
      tick();
      g++;
    end
    acc = cyc;
    n_cmp++;
    if (g >= 200) begin
      n_bad++;
      $display("FAIL send_accept: ready got 0 want 1");
    end
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int g;
    g = 0;
    while (q_res.size() < n && g < 300) begin
      tick();
      g++;
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) tick();
    reset_i = 1'b0;
    n_cmp++;
    if (cmd_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_ready: got %b want 1", cmd_ready_o);
    end
    n_cmp++;
    if ({busy_o, rsp_valid_o, alu_start_o, rsp_error_o} !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_flags: got %b want 0000",
               {busy_o, rsp_valid_o, alu_start_o, rsp_error_o});
    end
    n_cmp++;
    if ({alu_a_o, alu_b_o, alu_opcode_o, rsp_result_o, rsp_opcode_o} !== '0) begin
      n_bad++;
      $display("FAIL rst_data: got %h want 0",
               {alu_a_o, alu_b_o, alu_opcode_o, rsp_result_o, rsp_opcode_o});
    end
    tick();
  endtask

  task automatic test_add_latency();
    int base, acc, s0;
    rsp_ready_i = 1'b1;
    base = q_res.size();
    s0 = start_cnt;
    send(8'hFF, 8'h01, 3'd1, acc);
    wait_rsp(base + 1);
    n_cmp++;
    if (q_res.size() != base + 1) begin
      n_bad++;
      $display("FAIL add_count: got %0d want %0d", q_res.size(), base + 1);
    end else begin
      n_cmp++;
      if (q_res[base] !== 16'h0100 || q_err[base] !== 1'b0 || q_op[base] !== 3'd1) begin
        n_bad++;
        $display("FAIL add_rsp: got %h/%b/%0d want 0100/0/1",
                 q_res[base], q_err[base], q_op[base]);
      end
    end
    n_cmp++;
    if (last_start != acc + 2) begin
      n_bad++;
      $display("FAIL add_start_lat: got %0d want %0d", last_start, acc + 2);
    end
    n_cmp++;
    if (valid_rise != acc + 4) begin
      n_bad++;
      $display("FAIL add_valid_lat: got %0d want %0d", valid_rise, acc + 4);
    end
    n_cmp++;
    if (start_cnt != s0 + 1) begin
      n_bad++;
      $display("FAIL add_starts: got %0d want %0d", start_cnt, s0 + 1);
    end
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL add_idle: busy got %b want 0", busy_o);
    end
  endtask

  task automatic test_mul_nop();
    int base, acc;
    rsp_ready_i = 1'b1;
    base = q_res.size();
    send(8'hFF, 8'hFF, 3'd4, acc);
    send(8'h12, 8'h34, 3'd0, acc);
    wait_rsp(base + 2);
    n_cmp++;
    if (q_res.size() != base + 2) begin
      n_bad++;
      $display("FAIL mul_count: got %0d want %0d", q_res.size(), base + 2);
    end else begin
      n_cmp++;
      if (q_res[base] !== 16'hFE01 || q_op[base] !== 3'd4 || q_err[base] !== 1'b0) begin
        n_bad++;
        $display("FAIL mul_rsp: got %h/%0d/%b want FE01/4/0",
                 q_res[base], q_op[base], q_err[base]);
      end
      n_cmp++;
      if (q_res[base+1] !== 16'h0000 || q_op[base+1] !== 3'd0 || q_err[base+1] !== 1'b0) begin
        n_bad++;
        $display("FAIL nop_rsp: got %h/%0d/%b want 0000/0/0",
                 q_res[base+1], q_op[base+1], q_err[base+1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base, g;
    logic [5:0] acc_bits;
    rsp_ready_i = 1'b0;
    base = q_res.size();
    acc_bits = '0;
    for (int i = 0; i < 6; i++) begin
      cmd_a_i      = 8'(i + 1);
      cmd_b_i      = 8'h10;
      cmd_opcode_i = 3'd1;
      cmd_valid_i  = 1'b1;
      acc_bits[i]  = cmd_ready_o;
      tick();
    end
    n_cmp++;
    if (acc_bits !== 6'b011111) begin
      n_bad++;
      $display("FAIL b2b_accepts: got %b want 011111", acc_bits);
    end
    n_cmp++;
    if (cmd_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_full: ready/busy got %b%b want 01", cmd_ready_o, busy_o);
    end
    n_cmp++;
    if (rsp_valid_o !== 1'b1 || rsp_result_o !== 16'h0011) begin
      n_bad++;
      $display("FAIL b2b_head: valid/result got %b/%h want 1/0011",
               rsp_valid_o, rsp_result_o);
    end
    repeat (3) tick();
    n_cmp++;
    if (cmd_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_hold_full: ready got %b want 0", cmd_ready_o);
    end
    rsp_ready_i = 1'b1;
    g = 0;
    while (!cmd_ready_o && g < 100) begin
      tick();
      g++;
    end
    tick();
    cmd_valid_i = 1'b0;
    n_cmp++;
    if (g >= 100) begin
      n_bad++;
      $display("FAIL b2b_sixth: ready got 0 want 1");
    end
    wait_rsp(base + 6);
    n_cmp++;
    if (q_res.size() != base + 6) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d want %0d", q_res.size(), base + 6);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (q_res[base+i] !== 16'h0011 + 16'(i) || q_err[base+i] !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_order%0d: got %h/%b want %h/0",
                   i, q_res[base+i], q_err[base+i], 16'h0011 + 16'(i));
        end
      end
    end
  endtask

  task automatic test_timeout();
    int base, acc;
    rsp_ready_i = 1'b1;
    base = q_res.size();
    send(8'h01, 8'h02, 3'd5, acc);
    wait_rsp(base + 1);
    n_cmp++;
    if (valid_rise != acc + 19) begin
      n_bad++;
      $display("FAIL tmo_lat: got %0d want %0d", valid_rise, acc + 19);
    end
    n_cmp++;
    if (q_res.size() != base + 1) begin
      n_bad++;
      $display("FAIL tmo_count: got %0d want %0d", q_res.size(), base + 1);
    end else begin
      n_cmp++;
      if (q_err[base] !== 1'b1 || q_res[base] !== 16'h0000 || q_op[base] !== 3'd5) begin
        n_bad++;
        $display("FAIL tmo_rsp: got %b/%h/%0d want 1/0000/5",
                 q_err[base], q_res[base], q_op[base]);
      end
    end
    send(8'h02, 8'h03, 3'd1, acc);
    wait_rsp(base + 2);
    n_cmp++;
    if (q_res.size() != base + 2) begin
      n_bad++;
      $display("FAIL tmo_next_count: got %0d want %0d", q_res.size(), base + 2);
    end else begin
      n_cmp++;
      if (q_res[base+1] !== 16'h0005 || q_err[base+1] !== 1'b0) begin
        n_bad++;
        $display("FAIL tmo_next: got %h/%b want 0005/0", q_res[base+1], q_err[base+1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int base, acc, g, s0;
    logic stable;
    rsp_ready_i = 1'b0;
    base = q_res.size();
    send(8'h07, 8'h08, 3'd1, acc);
    send(8'h01, 8'h02, 3'd1, acc);
    g = 0;
    while (!rsp_valid_o && g < 50) begin
      tick();
      g++;
    end
    s0 = start_cnt;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid_o !== 1'b1 || rsp_result_o !== 16'h000F ||
          rsp_opcode_o !== 3'd1 || rsp_error_o !== 1'b0) stable = 1'b0;
      inj_done = (i == 3);
      tick();
    end
    inj_done = 1'b0;
    n_cmp++;
    if (stable !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_stable: got %b want 1", stable);
    end
    n_cmp++;
    if (start_cnt != s0) begin
      n_bad++;
      $display("FAIL bp_no_start: got %0d want %0d", start_cnt, s0);
    end
    rsp_ready_i = 1'b1;
    wait_rsp(base + 2);
    n_cmp++;
    if (q_res.size() != base + 2) begin
      n_bad++;
      $display("FAIL bp_count: got %0d want %0d", q_res.size(), base + 2);
    end else begin
      n_cmp++;
      if (q_res[base] !== 16'h000F || q_res[base+1] !== 16'h0003 ||
          q_err[base] !== 1'b0 || q_err[base+1] !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_rsp: got %h %h want 000F 0003", q_res[base], q_res[base+1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base, acc, s0, nr;
    rsp_ready_i = 1'b1;
    send(8'h01, 8'h01, 3'd5, acc);
    send(8'h03, 8'h04, 3'd1, acc);
    send(8'h05, 8'h06, 3'd1, acc);
    send(8'h07, 8'h08, 3'd1, acc);
    repeat (2) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    n_cmp++;
    if ({cmd_ready_o, busy_o, rsp_valid_o, alu_start_o, rsp_error_o} !== 5'b10000) begin
      n_bad++;
      $display("FAIL mid_rst_flags: got %b want 10000",
               {cmd_ready_o, busy_o, rsp_valid_o, alu_start_o, rsp_error_o});
    end
    n_cmp++;
    if ({alu_a_o, alu_b_o, alu_opcode_o, rsp_result_o, rsp_opcode_o} !== '0) begin
      n_bad++;
      $display("FAIL mid_rst_data: got %h want 0",
               {alu_a_o, alu_b_o, alu_opcode_o, rsp_result_o, rsp_opcode_o});
    end
    nr = q_res.size();
    s0 = start_cnt;
    repeat (30) tick();
    n_cmp++;
    if (q_res.size() != nr || start_cnt != s0) begin
      n_bad++;
      $display("FAIL mid_rst_discard: rsp/starts got %0d/%0d want %0d/%0d",
               q_res.size(), start_cnt, nr, s0);
    end
    base = q_res.size();
    send(8'h01, 8'h01, 3'd1, acc);
    wait_rsp(base + 1);
    n_cmp++;
    if (q_res.size() != base + 1) begin
      n_bad++;
      $display("FAIL mid_rst_count: got %0d want %0d", q_res.size(), base + 1);
    end else begin
      n_cmp++;
      if (q_res[base] !== 16'h0002 || q_err[base] !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_rst_add: got %h/%b want 0002/0", q_res[base], q_err[base]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_latency();
    test_mul_nop();
    test_back_to_back();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
